// File: rtl/bus_pkg.sv
// Shared field positions, command encodings and FSM state codes for the snoop bus.
package bus_pkg;

   // Field widths of the cpu message and the returned bus word.
   localparam int unsigned MSG_W  = 10;
   localparam int unsigned BUS_W  = 11;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned CMD_W  = 2;

   // Bit positions inside a cpu message.
   localparam int unsigned CMD_RD  = 9;
   localparam int unsigned CMD_WR  = 8;
   localparam int unsigned CMD_INV = 7;
   localparam int unsigned ADDR_LO = 4;
   localparam int unsigned DATA_LO = 0;

   // Bus command encodings.
   localparam logic [CMD_W-1:0] CMD_ENC_RD  = 2'b01;
   localparam logic [CMD_W-1:0] CMD_ENC_WR  = 2'b10;
   localparam logic [CMD_W-1:0] CMD_ENC_INV = 2'b11;

   // Arbiter FSM states.
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SNOOP = 3'd1;
   localparam state_t ST_RESP  = 3'd2;
   localparam state_t ST_MEM   = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   // Collapse the {readMiss, writeMiss, invalidate} bits, readMiss highest priority.
   function automatic logic [CMD_W-1:0] encode_cmd(input logic [2:0] bits);
      logic [CMD_W-1:0] enc;
      enc = '0;
      if (bits[2])      enc = CMD_ENC_RD;
      else if (bits[1]) enc = CMD_ENC_WR;
      else if (bits[0]) enc = CMD_ENC_INV;
      return enc;
   endfunction

   // Assemble one cpu_bus_in word.
   function automatic logic [BUS_W-1:0] bus_word(input logic snoop, input logic done,
                                                 input logic [CMD_W-1:0] cmd,
                                                 input logic [ADDR_W-1:0] addr,
                                                 input logic [DATA_W-1:0] data);
      return {snoop, done, cmd, addr, data};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N_CPU-way round-robin picker; search starts just after last_grant.
module rr_arbiter #(
   parameter int unsigned N_CPU = 2,
   localparam int unsigned IDX_W = (N_CPU > 1) ? $clog2(N_CPU) : 1
) (
   input  logic [N_CPU-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx
);

   int unsigned cand_c;

   // First requester found walking upward from last_grant+1, wrapping.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand_c    = 0;
      for (int unsigned k = 1; k <= N_CPU; k++) begin
         cand_c = (32'(last_grant) + k) % N_CPU;
         if (!gnt_valid && req[IDX_W'(cand_c)]) begin
            gnt_valid = 1'b1;
            gnt_idx   = IDX_W'(cand_c);
         end
      end
   end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping coherence bus sequencer: capture, round-robin grant, snoop broadcast,
// write-back collection, memory access and completion back to the requester.
module snoop_bus_arbiter import bus_pkg::*; #(
   parameter int unsigned N_CPU      = 2,
   parameter int unsigned SNOOP_WAIT = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_CPU*MSG_W-1:0]    cpu_bus_out,
   output logic [N_CPU*BUS_W-1:0]    cpu_bus_in,
   input  logic [N_CPU-1:0]          snoop_wb,
   input  logic [N_CPU*DATA_W-1:0]   snoop_data,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_we,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int unsigned IDX_W = (N_CPU > 1) ? $clog2(N_CPU) : 1;
   localparam int unsigned CNT_W = (SNOOP_WAIT > 1) ? $clog2(SNOOP_WAIT) : 1;

   state_t                            state_q, state_d;
   logic [N_CPU-1:0]                  pending_q, pending_d;
   logic [N_CPU-1:0][CMD_W-1:0]       msg_cmd_q, msg_cmd_d;
   logic [N_CPU-1:0][ADDR_W-1:0]      msg_addr_q, msg_addr_d;
   logic [IDX_W-1:0]                  last_grant_q, last_grant_d;
   logic [IDX_W-1:0]                  win_q, win_d;
   logic [CMD_W-1:0]                  cmd_q, cmd_d;
   logic [ADDR_W-1:0]                 addr_q, addr_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   logic                              wb_valid_q, wb_valid_d;
   logic [IDX_W-1:0]                  wb_idx_q, wb_idx_d;
   logic [DATA_W-1:0]                 wb_data_q, wb_data_d;
   logic [N_CPU*BUS_W-1:0]            cpu_bus_in_q, cpu_bus_in_d;
   logic [ADDR_W-1:0]                 mem_addr_q, mem_addr_d;
   logic                              mem_we_q, mem_we_d;
   logic [DATA_W-1:0]                 mem_wdata_q, mem_wdata_d;

   logic [IDX_W-1:0]                  rr_last_c;
   logic                              gnt_valid_c;
   logic [IDX_W-1:0]                  gnt_idx_c;
   logic [N_CPU-1:0]                  clr_c;
   logic                              try_grant_c;
   logic [DATA_W-1:0]                 fill_c;
   logic                              cur_any_c;
   logic [IDX_W-1:0]                  cur_idx_c;
   logic [DATA_W-1:0]                 cur_data_c;
   logic [2:0]                        req_bits_c;
   logic [N_CPU*DATA_W-1:0]           msg_data_unused;

   // Leaving DONE, the pointer must already reflect the transaction just finished.
   assign rr_last_c = (state_q == ST_DONE) ? win_q : last_grant_q;

   rr_arbiter #(.N_CPU(N_CPU)) u_rr (
      .req        (pending_q),
      .last_grant (rr_last_c),
      .gnt_valid  (gnt_valid_c),
      .gnt_idx    (gnt_idx_c)
   );

   // Message data field is carried on the bus but not needed for sequencing.
   always_comb begin
      msg_data_unused = '0;
      for (int unsigned i = 0; i < N_CPU; i++) begin
         msg_data_unused[i*DATA_W +: DATA_W] = cpu_bus_out[i*MSG_W + DATA_LO +: DATA_W];
      end
   end

   // Lowest-index snoop responder in the current cycle.
   always_comb begin
      cur_any_c  = 1'b0;
      cur_idx_c  = '0;
      cur_data_c = '0;
      for (int unsigned i = 0; i < N_CPU; i++) begin
         if (!cur_any_c && snoop_wb[i]) begin
            cur_any_c  = 1'b1;
            cur_idx_c  = IDX_W'(i);
            cur_data_c = snoop_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state, capture and registered-output computation.
   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      msg_cmd_d    = msg_cmd_q;
      msg_addr_d   = msg_addr_q;
      last_grant_d = last_grant_q;
      win_d        = win_q;
      cmd_d        = cmd_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      wb_valid_d   = wb_valid_q;
      wb_idx_d     = wb_idx_q;
      wb_data_d    = wb_data_q;
      cpu_bus_in_d = '0;
      mem_addr_d   = '0;
      mem_we_d     = 1'b0;
      mem_wdata_d  = '0;
      clr_c        = '0;
      try_grant_c  = 1'b0;
      fill_c       = '0;
      req_bits_c   = '0;

      case (state_q)
         ST_IDLE: try_grant_c = 1'b1;
         ST_SNOOP: begin
            state_d = ST_RESP;
            cnt_d   = '0;
         end
         ST_RESP: begin
            if (cur_any_c && (!wb_valid_q || (cur_idx_c < wb_idx_q))) begin
               wb_idx_d  = cur_idx_c;
               wb_data_d = cur_data_c;
            end
            wb_valid_d = wb_valid_q | cur_any_c;
            if (cnt_q == CNT_W'(SNOOP_WAIT - 1)) begin
               if ((cmd_q == CMD_ENC_RD) || ((cmd_q == CMD_ENC_WR) && wb_valid_d)) begin
                  state_d = ST_MEM;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_MEM: begin
            fill_c  = wb_valid_q ? wb_data_q : mem_rdata;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            last_grant_d = win_q;
            state_d      = ST_IDLE;
            try_grant_c  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (try_grant_c && gnt_valid_c) begin
         win_d             = gnt_idx_c;
         cmd_d             = msg_cmd_q[gnt_idx_c];
         addr_d            = msg_addr_q[gnt_idx_c];
         clr_c[gnt_idx_c]  = 1'b1;
         wb_valid_d        = 1'b0;
         wb_idx_d          = '0;
         wb_data_d         = '0;
         state_d           = ST_SNOOP;
      end

      // A new message is taken only if the slot is free or being granted this edge.
      for (int unsigned i = 0; i < N_CPU; i++) begin
         pending_d[i] = pending_q[i] & ~clr_c[i];
         req_bits_c   = cpu_bus_out[i*MSG_W + CMD_INV +: 3];
         if ((|req_bits_c) && (!pending_q[i] || clr_c[i])) begin
            pending_d[i]  = 1'b1;
            msg_cmd_d[i]  = encode_cmd(req_bits_c);
            msg_addr_d[i] = cpu_bus_out[i*MSG_W + ADDR_LO +: ADDR_W];
         end
      end

      case (state_d)
         ST_SNOOP: begin
            for (int unsigned j = 0; j < N_CPU; j++) begin
               if (IDX_W'(j) != win_d) begin
                  cpu_bus_in_d[j*BUS_W +: BUS_W] = bus_word(1'b1, 1'b0, cmd_d, addr_d, '0);
               end
            end
         end
         ST_MEM: begin
            mem_addr_d  = addr_d;
            mem_we_d    = wb_valid_d;
            mem_wdata_d = wb_valid_d ? wb_data_d : '0;
         end
         ST_DONE: begin
            cpu_bus_in_d[32'(win_d)*BUS_W +: BUS_W] = bus_word(1'b0, 1'b1, cmd_d, addr_d, fill_c);
         end
         default: ;
      endcase
   end

   // State and output registers; reset leaves CPU0 first in line.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pending_q    <= '0;
         msg_cmd_q    <= '0;
         msg_addr_q   <= '0;
         last_grant_q <= IDX_W'(N_CPU - 1);
         win_q        <= '0;
         cmd_q        <= '0;
         addr_q       <= '0;
         cnt_q        <= '0;
         wb_valid_q   <= 1'b0;
         wb_idx_q     <= '0;
         wb_data_q    <= '0;
         cpu_bus_in_q <= '0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         msg_cmd_q    <= msg_cmd_d;
         msg_addr_q   <= msg_addr_d;
         last_grant_q <= last_grant_d;
         win_q        <= win_d;
         cmd_q        <= cmd_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         wb_valid_q   <= wb_valid_d;
         wb_idx_q     <= wb_idx_d;
         wb_data_q    <= wb_data_d;
         cpu_bus_in_q <= cpu_bus_in_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign cpu_bus_in = cpu_bus_in_q;
   assign mem_addr   = mem_addr_q;
   assign mem_we     = mem_we_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Shares the single snooping coherence bus among `N_CPU` cpu instances and sequences each bus transaction. It latches the one-cycle `bus_out` messages (readMiss/writeMiss/invalidate), grants them in round-robin order, broadcasts the granted message to the other CPUs' snoopers, and collects any write-back from a Modified owner. It then performs the memory read or write and returns completion (`bus_in[9]`) with fill data to the requester. It sits between all cpu instances and main memory.

## Interface
- `N_CPU`, default 2: number of cpu ports, 2..4.
- `SNOOP_WAIT`, default 2: cycles in RESP collecting snoop responses, ≥1.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `cpu_bus_out`  in  `N_CPU*10`: per-CPU message.
  - [9] readMiss, [8] writeMiss, [7] invalidate, [6:4] addr, [3:0] data.
- `cpu_bus_in`  out  `N_CPU*11`: per-CPU bus word.
  - [10] snoop_valid, [9] done, [8:7] cmd (01 rd, 10 wr, 11 inv), [6:4] addr, [3:0] data.
- `snoop_wb`  in  `N_CPU`: CPU i holds the snooped address Modified and supplies data.
- `snoop_data`  in  `N_CPU*4`: write-back data, valid with `snoop_wb[i]`.
- `mem_addr`  out  3: memory address.
- `mem_we`  out  1: memory write strobe.
- `mem_wdata`  out  4: memory write data.
- `mem_rdata`  in  4: asynchronous read of `mem_addr`.

## Operation
- Capture:
  - Any of `cpu_bus_out[i][9:7]` set at a clock edge sets `pending[i]` and latches the message into `msg_q[i]`.
  - Multiple command bits set: priority readMiss > writeMiss > invalidate.
  - A new message from a CPU already pending is ignored; the first message is kept.
- States: IDLE, SNOOP, RESP, MEM, DONE.
- IDLE: if any pending, pick the winner round-robin starting at `last_grant+1`. Latch it, clear its pending bit, go to SNOOP. Set wins over clear on the same edge.
- SNOOP (1 cycle): `cpu_bus_in[j]` = {1, 0, cmd, addr, 0000} for every j ≠ winner. Winner sees all zeros.
- RESP (`SNOOP_WAIT` cycles): OR-accumulate `snoop_wb`. Keep the data of the lowest-index responder. Multiple responders is a protocol error; lowest index still wins.
- Exit from RESP:
  - readMiss → MEM.
  - writeMiss with write-back → MEM.
  - writeMiss without write-back → DONE.
  - invalidate → DONE.
- MEM (1 cycle):
  - With write-back: `mem_we`=1, `mem_addr`=addr, `mem_wdata`=wb data; fill = wb data.
  - Without write-back: `mem_we`=0, `mem_addr`=addr; fill = `mem_rdata`, sampled at MEM exit.
- DONE (1 cycle):
  - `cpu_bus_in[winner]` = {0, 1, cmd, addr, fill}.
  - Fill is 0000 for writeMiss without write-back and for invalidate.
  - `last_grant` ← winner; → IDLE.
- Reset, including mid-transaction:
  - state IDLE, all pending cleared, `last_grant` = `N_CPU-1` so CPU0 is served first.
  - All outputs zero.

## Timing
- Let E = capture edge; the request was driven in the cycle before E.
- Readmiss: SNOOP after E+1, RESP after E+2 … E+1+`SNOOP_WAIT`, MEM next, DONE next.
  - With `SNOOP_WAIT`=2: done high in the cycle after E+5.
- Invalidate, or writeMiss without write-back: done in the cycle after E+4.
- Back-to-back: next grant at the edge leaving DONE, so SNOOP follows DONE with zero idle cycles.
- Outputs are registered. `cpu_bus_in`, `mem_we`, `mem_addr` and `mem_wdata` are zero in every state/port not listed above.
- `done` is a single-cycle pulse.

## Structure
- Package `bus_pkg`:
  - message field indices (CMD_RD=9, CMD_WR=8, CMD_INV=7, ADDR 6:4, DATA 3:0);
  - 2-bit cmd encodings;
  - the arbiter state enum.
- Sub-module `rr_arbiter`: `N_CPU`-way round-robin picker; combinational grant from the pending vector and `last_grant`.
- Top module: capture registers, FSM, snoop accumulator, memory port.

## Test plan
- CPU0 readMiss addr 3'b010, mem[2]=4'h7, no snoop_wb → CPU1 sees snoop_valid with cmd 01 after E+1; CPU0 done with data 4'h7 after E+5; `mem_we` never high.
- CPU0 readMiss addr 5, CPU1 `snoop_wb` data 4'hA during RESP → `mem_we`=1, `mem_addr`=5, `mem_wdata`=4'hA in MEM; CPU0 done with data 4'hA.
- CPU1 invalidate addr 4 → CPU0 snoop_valid, cmd 11; CPU1 done after E+4 with data 0000; no memory access.
- CPU0 and CPU1 request on the same edge after reset → CPU0 served first, CPU1 granted on the edge leaving CPU0's DONE; then CPU0 re-requests while CPU1 is active → CPU0 served after CPU1.
- Reset asserted during RESP → all outputs zero immediately; pending empty; a subsequent CPU1 writeMiss with no write-back completes normally after E+4.
- CPU0 sends a second message while pending → the second message is ignored; done returns the first message's cmd/addr.
